// File: rtl/bcd_arb_pkg.sv
// rtl/bcd_arb_pkg.sv - shared types and defaults for the BCD converter arbiter
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE
  } arb_state_t;

  typedef logic [6:0] seg_t;

  localparam int DEF_WORD_LENGTH = 8;
  localparam int DEF_NUM_REQ     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_idx,
  output logic               any
);

  logic [PW-1:0] idx;

  // Walk from the farthest candidate back to the pointer so the closest requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(pointer) + k) % NUM_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - shares one binary-to-BCD converter among NUM_REQ requesters
// Optional WAIT watchdog and sticky err flag: define BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int WORD_LENGTH    = DEF_WORD_LENGTH,
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] bin_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output seg_t                           U,
  output seg_t                           T,
  output seg_t                           H,
  output logic                           sign,
  output logic                           busy,
  output logic                           err,
  output logic                           conv_start,
  output logic [WORD_LENGTH-1:0]         conv_bin,
  input  logic                           conv_ready,
  input  seg_t                           conv_U,
  input  seg_t                           conv_T,
  input  seg_t                           conv_H,
  input  logic                           conv_sign
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bcd_conv_arbiter: unsupported parameter set");
  end

  arb_state_t             state, state_nx;
  logic [NUM_REQ-1:0]     arb_grant;
  logic [PW-1:0]          arb_idx, g_idx, ptr;
  logic                   arb_any, armed, ready_hit, tmo_hit;
  logic [WORD_LENGTH-1:0] bin_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req       (req),
    .pointer   (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    bin_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == PW'(i)) bin_sel = bin_in[i*WORD_LENGTH +: WORD_LENGTH];
    end
  end

  // Only a ready that follows a seen-low ready belongs to the current job.
  assign ready_hit = (state == WAIT) && armed && conv_ready;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign tmo_hit = (state == WAIT) && !ready_hit && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == LAUNCH)    tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit)            err_q   <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable && arb_any) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (ready_hit || tmo_hit) state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign conv_start = (state == LAUNCH);
  assign busy       = (state != IDLE);
  assign done       = (state == CAPTURE) ? grant : '0;

  // Results are latched on entry to CAPTURE so they are valid while done is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant    <= '0;
      g_idx    <= '0;
      ptr      <= '0;
      armed    <= 1'b0;
      conv_bin <= '0;
      U        <= '0;
      T        <= '0;
      H        <= '0;
      sign     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && arb_any) begin
            grant    <= arb_grant;
            g_idx    <= arb_idx;
            conv_bin <= bin_sel;
          end
        end
        LAUNCH: armed <= 1'b0;
        WAIT: begin
          if (!conv_ready) armed <= 1'b1;
          if (ready_hit) begin
            U    <= conv_U;
            T    <= conv_T;
            H    <= conv_H;
            sign <= conv_sign;
          end
        end
        CAPTURE: begin
          grant <= '0;
          ptr   <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
